// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB master port.
// Latches the winning request, pulses m_start, waits for m_stable or a timeout, then acks the winner.
module apb_req_arbiter #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [1:0]        r0_sel,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_err,
   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [1:0]        r1_sel,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_err,
   output logic              m_start,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [1:0]        m_sel,
   input  logic              m_stable,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy,
   output logic              grant_id
);

   // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]       state;
   logic             ptr;
   logic             err_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             win;
   logic             timed_out;

   // ptr names the requester favoured when both ask in the same cycle.
   always_comb begin
      win = r1_req;
      if (r0_req && r1_req) begin
         win = ptr;
      end
   end

   assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         ptr      <= 1'b0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
         grant_id <= 1'b0;
         m_write  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         m_sel    <= '0;
         r0_rdata <= '0;
         r1_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (r0_req || r1_req) begin
                  grant_id <= win;
                  m_write  <= win ? r1_write : r0_write;
                  m_addr   <= win ? r1_addr  : r0_addr;
                  m_wdata  <= win ? r1_wdata : r0_wdata;
                  m_sel    <= win ? r1_sel   : r0_sel;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               err_q    <= 1'b0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               // A completion arriving on the final allowed cycle beats the timeout.
               if (m_stable) begin
                  if (!m_write) begin
                     if (grant_id) begin
                        r1_rdata <= m_rdata;
                     end else begin
                        r0_rdata <= m_rdata;
                     end
                  end
                  err_q <= 1'b0;
                  state <= ST_RESP;
               end else if (timed_out) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               ptr   <= ~grant_id;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_start = (state == ST_ISSUE);
   assign busy    = (state != ST_IDLE);
   assign r0_ack  = (state == ST_RESP) && !grant_id;
   assign r1_ack  = (state == ST_RESP) &&  grant_id;
   assign r0_err  = r0_ack && err_q;
   assign r1_err  = r1_ack && err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomised scoreboard bench for apb_req_arbiter: a round-robin service model plans each
// transfer, a master responder answers m_start, and a monitor checks every ack.
module tb_apb_req_arbiter;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;

   typedef struct {
      bit         write;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [1:0] sel;
      logic [7:0] rdata;
      int         delay;
   } txn_t;

   typedef struct {
      txn_t t;
      bit   id;
   } plan_t;

   typedef struct {
      bit         id;
      bit         err;
      logic [7:0] rdata;
      logic [7:0] other_rdata;
      int         latency;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       r0_req, r0_write, r1_req, r1_write;
   logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic [1:0] r0_sel, r1_sel;
   logic       r0_ack, r0_err, r1_ack, r1_err;
   logic [7:0] r0_rdata, r1_rdata;
   logic       m_start, m_write, m_stable, busy, grant_id;
   logic [7:0] m_addr, m_wdata, m_rdata;
   logic [1:0] m_sel;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    start_cyc = 0;
   bit    aborted = 1'b0;
   bit    stray_mode = 1'b0;
   bit    favour = 1'b0;
   logic [7:0] model_rdata [2];
   plan_t plan_q [$];
   exp_t  exp_q [$];
   txn_t  stim0 [$];
   txn_t  stim1 [$];

   apb_req_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_sel(r0_sel), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
      .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_sel(r1_sel), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
      .m_start(m_start), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_sel(m_sel), .m_stable(m_stable), .m_rdata(m_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic txn_t mk(input bit w, input logic [7:0] a, input logic [7:0] wd,
                               input logic [1:0] s, input logic [7:0] rd, input int d);
      txn_t t;
      t.write = w; t.addr = a; t.wdata = wd; t.sel = s; t.rdata = rd; t.delay = d;
      return t;
   endfunction

   // delay 0 means the master never answers; TIMEOUT and TIMEOUT-1 probe the deadline edge.
   function automatic txn_t rand_txn(input bit allow_timeout);
      txn_t t;
      int   pick;
      t.write = 1'($urandom_range(0, 1));
      t.addr  = 8'($urandom);
      t.wdata = 8'($urandom);
      t.sel   = 2'($urandom_range(1, 2));
      t.rdata = 8'($urandom);
      pick    = int'($urandom_range(0, 9));
      if (allow_timeout && pick == 0) t.delay = 0;
      else if (pick == 1)             t.delay = TIMEOUT;
      else if (pick == 2)             t.delay = TIMEOUT - 1;
      else                            t.delay = int'($urandom_range(1, 5));
      return t;
   endfunction

   // Service order: alternate while both lists have work, otherwise drain whichever remains.
   task automatic plan_round();
      int    i0 = 0;
      int    i1 = 0;
      bit    id;
      txn_t  t;
      exp_t  e;
      plan_t p;
      while (i0 < stim0.size() || i1 < stim1.size()) begin
         if (i0 < stim0.size() && i1 < stim1.size()) id = favour;
         else id = (i1 < stim1.size());
         if (id) begin t = stim1[i1]; i1++; end
         else    begin t = stim0[i0]; i0++; end
         p.t = t; p.id = id;
         plan_q.push_back(p);
         if (!t.write && t.delay != 0) model_rdata[id] = t.rdata;
         e.id          = id;
         e.err         = (t.delay == 0);
         e.rdata       = model_rdata[id];
         e.other_rdata = model_rdata[!id];
         e.latency     = (t.delay == 0) ? TIMEOUT + 1 : t.delay + 1;
         exp_q.push_back(e);
         favour = !id;
      end
   endtask

   task automatic drive0(input txn_t t);
      r0_write = t.write; r0_addr = t.addr; r0_wdata = t.wdata; r0_sel = t.sel; r0_req = 1'b1;
   endtask

   task automatic drive1(input txn_t t);
      r1_write = t.write; r1_addr = t.addr; r1_wdata = t.wdata; r1_sel = t.sel; r1_req = 1'b1;
   endtask

   // Requesters drop on ack and re-raise the next cycle, so both stay pending between grants.
   task automatic applyStimulus();
      int i0 = 0;
      int i1 = 0;
      int budget = 0;
      if (aborted) begin
         stim0.delete(); stim1.delete();
         return;
      end
      plan_round();
      @(negedge clk);
      if (stim0.size() > 0) drive0(stim0[0]);
      if (stim1.size() > 0) drive1(stim1[0]);
      while ((i0 < stim0.size() || i1 < stim1.size()) && !aborted) begin
         @(negedge clk);
         budget++;
         if (r0_ack) begin r0_req = 1'b0; i0++; end
         else if (!r0_req && i0 < stim0.size()) drive0(stim0[i0]);
         if (r1_ack) begin r1_req = 1'b0; i1++; end
         else if (!r1_req && i1 < stim1.size()) drive1(stim1[i1]);
         if (budget > 1000) begin
            checks++; failures++; aborted = 1'b1;
            $display("[TB] FAIL round_budget: got %0d acks expected %0d", i0 + i1, stim0.size() + stim1.size());
         end
      end
      stim0.delete(); stim1.delete();
   endtask

   // Master responder: checks the latched request on m_start and answers after the planned delay.
   initial begin : responder
      bit         inflight = 1'b0;
      int         remaining = 0;
      logic [7:0] cur_rdata = 8'h00;
      plan_t      p;
      m_stable = 1'b0;
      m_rdata  = 8'h00;
      forever begin
         @(negedge clk);
         m_stable = 1'b0;
         if (reset) begin
            inflight = 1'b0;
            remaining = 0;
         end else begin
            if (r0_ack || r1_ack) inflight = 1'b0;
            if (m_start) begin
               check("no_overlap_start", 32'(inflight), 32'd0);
               check("start_planned", 32'(plan_q.size() > 0), 32'd1);
               if (plan_q.size() > 0 && !inflight) begin
                  p = plan_q.pop_front();
                  check("m_fields", 32'({grant_id, m_write, m_sel, m_addr, m_wdata}),
                        32'({p.id, p.t.write, p.t.sel, p.t.addr, p.t.wdata}));
                  inflight  = 1'b1;
                  remaining = p.t.delay;
                  cur_rdata = p.t.rdata;
                  start_cyc = cyc;
               end
            end else if (inflight && remaining > 0) begin
               remaining--;
               if (remaining == 0) begin
                  m_stable = 1'b1;
                  m_rdata  = cur_rdata;
               end
            end else if (!inflight && stray_mode) begin
               m_stable = 1'($urandom_range(0, 1));
               m_rdata  = 8'($urandom);
            end
         end
      end
   end

   task automatic checkOutput();
      exp_t e;
      bit   id;
      check("ack_onehot", 32'(r0_ack && r1_ack), 32'd0);
      check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0 && !(r0_ack && r1_ack)) begin
         e  = exp_q.pop_front();
         id = r1_ack;
         check("ack_id", 32'(id), 32'(e.id));
         check("ack_err", 32'(id ? r1_err : r0_err), 32'(e.err));
         check("ack_rdata", 32'(id ? r1_rdata : r0_rdata), 32'(e.rdata));
         check("other_rdata", 32'(id ? r0_rdata : r1_rdata), 32'(e.other_rdata));
         check("ack_latency", 32'(cyc - start_cyc), 32'(e.latency));
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset && (r0_ack || r1_ack)) checkOutput();
      end
   end

   initial begin : watchdog
      #1000000;
      failures++;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      plan_t p;
      bit    seen;
      int    n0, n1;
      reset = 1'b1;
      r0_req = 1'b0; r0_write = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00; r0_sel = 2'd0;
      r1_req = 1'b0; r1_write = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00; r1_sel = 2'd0;
      model_rdata[0] = 8'h00;
      model_rdata[1] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({busy, m_start, m_write, m_sel, m_addr, m_wdata, grant_id,
                                  r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
      check("reset_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 32'({busy, m_start}), 32'd0);

      stim0.push_back(mk(1'b1, 8'd5, 8'd4, 2'd1, 8'h99, 3));
      applyStimulus();
      stim1.push_back(mk(1'b0, 8'd6, 8'd0, 2'd1, 8'd7, 1));
      applyStimulus();

      for (int i = 0; i < 3; i++) begin
         stim0.push_back(rand_txn(1'b0));
         stim1.push_back(rand_txn(1'b0));
      end
      applyStimulus();

      stim0.push_back(mk(1'b0, 8'h40, 8'h00, 2'd2, 8'h5a, 0));
      stim0.push_back(mk(1'b0, 8'h41, 8'h00, 2'd1, 8'hc3, 2));
      applyStimulus();

      // Abort an r1 transfer mid-wait; the master never answers and no ack may follow.
      if (!aborted) begin
         p.id = 1'b1;
         p.t  = mk(1'b1, 8'hA7, 8'h3C, 2'd2, 8'h00, 0);
         plan_q.push_back(p);
         @(negedge clk);
         drive1(p.t);
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_start) seen = 1'b1;
         end
         check("reset_test_started", 32'(seen), 32'd1);
         repeat (4) @(negedge clk);
         #2 reset = 1'b1;
         #1;
         check("async_reset_outputs", 32'({busy, m_start, m_write, m_sel, m_addr, m_wdata, grant_id,
                                           r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
         check("async_reset_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
         r1_req = 1'b0;
         favour = 1'b0;
         model_rdata[0] = 8'h00;
         model_rdata[1] = 8'h00;
         @(negedge clk);
         #2 reset = 1'b0;
      end
      stim0.push_back(rand_txn(1'b0));
      stim1.push_back(rand_txn(1'b0));
      applyStimulus();
      stim1.push_back(mk(1'b0, 8'h22, 8'h00, 2'd1, 8'h6e, 2));
      applyStimulus();

      stray_mode = 1'b1;
      repeat (20) @(negedge clk);
      stray_mode = 1'b0;
      repeat (2) @(negedge clk);
      check("stray_r0_rdata", 32'(r0_rdata), 32'(model_rdata[0]));
      check("stray_r1_rdata", 32'(r1_rdata), 32'(model_rdata[1]));
      check("stray_idle", 32'(busy), 32'd0);

      for (int r = 0; r < 25; r++) begin
         n0 = int'($urandom_range(0, 3));
         n1 = int'($urandom_range(0, 3));
         if (n0 == 0 && n1 == 0) n0 = 1;
         for (int i = 0; i < n0; i++) stim0.push_back(rand_txn(1'b1));
         for (int i = 0; i < n1; i++) stim1.push_back(rand_txn(1'b1));
         applyStimulus();
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("plan_drained", 32'(plan_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
